// File: rtl/seq_div_pkg.sv
// Shared constants and helpers for the sequential restoring divider.
// Covers the FSM state encodings, the default operand width and the conditional two's-complement negate.
package seq_div_pkg;

    localparam logic [1:0] S_IDLE = 2'b01;
    localparam logic [1:0] S_ITER = 2'b10;
    localparam logic [1:0] S_FIX  = 2'b11;

    localparam int N_DEFAULT = 8;

    // Width-agnostic negate for operands up to 32 bits.
    // Callers zero-extend the operand and truncate the result back to their width.
    function automatic logic [31:0] cond_negate(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring step: shift {R,Q} left by one, trial-subtract the divisor.
// Commit the difference only when it does not borrow.
module div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   rem_in,
    input  logic [N-1:0] quo_in,
    input  logic [N-1:0] dvs,
    output logic [N:0]   rem_out,
    output logic [N-1:0] quo_out
);

    logic [N+1:0] shifted;
    logic [N+1:0] trial;
    logic         fits;

    // One extra bit above R catches the borrow of the trial subtraction.
    always_comb begin
        shifted = {rem_in, quo_in[N-1]};
        trial   = shifted - {2'b00, dvs};
        fits    = ~trial[N+1];
        rem_out = fits ? trial[N:0] : shifted[N:0];
        quo_out = {quo_in[N-2:0], fits};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [N-1:0]     dividend,
    input  logic [N-1:0]     divisor,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] count
);

    logic [N:0]   rem_r;
    logic [N-1:0] quo_r;
    logic [N-1:0] dvs_mag;
    logic [N-1:0] dvd_orig;
    logic         dvs_zero;

    logic [N-1:0] mag_a;
    logic [N-1:0] mag_d;
    logic [N:0]   rem_nx;
    logic [N-1:0] quo_nx;
    logic [N-1:0] q_fix;
    logic [N-1:0] r_fix;

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
`endif

    // Operand magnitudes; |-2^(N-1)| = 2^(N-1) still fits in N unsigned bits.
    always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
        mag_a = N'(cond_negate(32'(dividend), dividend[N-1]));
        mag_d = N'(cond_negate(32'(divisor), divisor[N-1]));
`else
        mag_a = dividend;
        mag_d = divisor;
`endif
    end

    div_step #(.N(N)) u_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .dvs     (dvs_mag),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // Result fix-up: quotient takes the XOR of signs, remainder the dividend's sign.
    always_comb begin
        q_fix = quo_r;
        r_fix = rem_r[N-1:0];
`ifdef SEQ_DIV_SIGNED_EN
        q_fix = N'(cond_negate(32'(quo_r), neg_q));
        r_fix = N'(cond_negate(32'(rem_r[N-1:0]), neg_r));
`endif
        if (dvs_zero) begin
            q_fix = '1;
            r_fix = dvd_orig;
        end
    end

    assign busy = (state == S_ITER) || (state == S_FIX);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            count       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvs_mag     <= mag_d;
                        dvd_orig    <= dividend;
                        dvs_zero    <= (divisor == '0);
`ifdef SEQ_DIV_SIGNED_EN
                        neg_q       <= dividend[N-1] ^ divisor[N-1];
                        neg_r       <= dividend[N-1];
`endif
                        count       <= '0;
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                        rem_r       <= '0;
                        quo_r       <= mag_a;
                        state       <= S_ITER;
                    end
                end
                S_ITER: begin
                    rem_r <= rem_nx;
                    quo_r <= quo_nx;
                    count <= count + 1'b1;
                    if (count == CNT_W'(N - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient    <= q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= dvs_zero;
                    done        <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=8): hand-computed vectors for both builds of SEQ_DIV_SIGNED_EN.
module tb_seq_divider;

    logic       Clock;
    logic       Reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       done;
    logic       busy;
    logic       div_by_zero;
    logic [1:0] state;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.N(8), .CNT_W(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .state       (state),
        .count       (count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start one division and wait for done; lat counts edges after the accepting edge.
    task automatic run_div(input logic [7:0] a, input logic [7:0] d, input bit toggle,
                           output int lat, output int nbusy);
        @(negedge Clock);
        dividend = a;
        divisor  = d;
        start    = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        nbusy = busy ? 1 : 0;
        lat   = 0;
        while (lat < 40) begin
            if (toggle) begin
                if (lat == 2 || lat == 4) begin
                    start    = 1'b1;
                    dividend = 8'h11;
                    divisor  = 8'h03;
                end else begin
                    start = 1'b0;
                end
            end
            @(posedge Clock);
            #1;
            lat++;
            if (done) break;
            if (busy) nbusy++;
        end
        start = 1'b0;
    endtask

    task automatic div_check(input string tag, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] eq, input logic [7:0] er, input logic ez,
                             input bit toggle);
        int lat;
        int nbusy;
        run_div(a, d, toggle, lat, nbusy);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'd9);
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
        check({tag, " busy cycles"}, 32'(nbusy), 32'd9);
        check({tag, " busy after done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int nbusy;
        Reset    = 1'b1;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        repeat (2) @(posedge Clock);
        #1;
        check("reset state", 32'(state), 32'h1);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        start = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;

        div_check("100/7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0);
`ifdef SEQ_DIV_SIGNED_EN
        div_check("-100/7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0);
        div_check("100/-7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
        div_check("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0);
        div_check("-56/3", 8'hC8, 8'd3, 8'hEE, 8'hFE, 1'b0, 1'b0);
`else
        div_check("156/7", 8'h9C, 8'd7, 8'h16, 8'h02, 1'b0, 1'b0);
        div_check("100/249", 8'd100, 8'hF9, 8'h00, 8'h64, 1'b0, 1'b0);
        div_check("128/255", 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0);
        div_check("200/3", 8'hC8, 8'd3, 8'h42, 8'h02, 1'b0, 1'b0);
`endif
        div_check("7/0", 8'd7, 8'd0, 8'hFF, 8'h07, 1'b1, 1'b0);
        div_check("7/1", 8'd7, 8'd1, 8'h07, 8'h00, 1'b0, 1'b0);

        // Abort a division after its fourth iteration.
        @(negedge Clock);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        check("mid count", 32'(count), 32'd4);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("abort state", 32'(state), 32'h1);
        check("abort done", 32'(done), 32'd0);
        check("abort count", 32'(count), 32'd0);
        check("abort quotient", 32'(quotient), 32'd0);
        check("abort remainder", 32'(remainder), 32'd0);
        Reset = 1'b0;
        div_check("50/5", 8'd50, 8'd5, 8'h0A, 8'h00, 1'b0, 1'b0);

        div_check("toggle 100/7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b1);

        // start held across done: one-cycle done, then a fresh division.
        @(negedge Clock);
        dividend = 8'd50;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge Clock);
        #1;
        lat = 0;
        while (lat < 40) begin
            @(posedge Clock);
            #1;
            lat++;
            if (done) break;
        end
        check("held latency", 32'(lat), 32'd9);
        check("held quotient", 32'(quotient), 32'h07);
        check("held remainder", 32'(remainder), 32'h01);
        @(posedge Clock);
        #1;
        check("held done drop", 32'(done), 32'd0);
        check("held restart busy", 32'(busy), 32'd1);
        check("held restart state", 32'(state), 32'h2);
        start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge Clock);
            #1;
            lat++;
            if (done) break;
        end
        check("held second latency", 32'(lat), 32'd9);
        check("held second quotient", 32'(quotient), 32'h07);
        check("held second remainder", 32'(remainder), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
